// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding, data width, line levels.
package uart_tx_buffered_pkg;

    localparam int unsigned UART_DATA_W = 8;
    localparam logic        IDLE_LEVEL  = 1'b1;
    localparam logic        START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } tx_state_e;

    function automatic logic even_parity(input logic [UART_DATA_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with asynchronous active-high reset; DEPTH must be a power of two.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = DEPTH[PtrW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FullCount);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed frame serializer, start + 8 data bits MSB first + stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop bits.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned STOP_BITS    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] data_in_i,
    input  logic                   wr_en_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   bit_out_o,
    output logic                   busy_o,
    output logic                   tx_done_o,
    output logic                   overflow_o
);

    localparam int unsigned CycW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_e              state_q, state_d;
    logic [UART_DATA_W-1:0] shreg_q, shreg_d;
    logic [CycW-1:0]        cyc_q, cyc_d;
    logic [7:0]             bcnt_q, bcnt_d;
    logic                   bit_out_q, bit_out_d;
    logic                   overflow_q, overflow_d;
    logic                   bit_tick, last_stop, fifo_pop;
    logic [UART_DATA_W-1:0] fifo_rdata;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(UART_DATA_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (wr_en_i),
        .wdata_i(data_in_i),
        .pop_i  (fifo_pop),
        .rdata_o(fifo_rdata),
        .full_o (full_o),
        .empty_o(empty_o)
    );

    assign bit_tick  = (cyc_q == CycW'(CLKS_PER_BIT - 1));
    assign last_stop = (bcnt_q == 8'(STOP_BITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            cyc_q      <= '0;
            bcnt_q     <= '0;
            bit_out_q  <= IDLE_LEVEL;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cyc_q      <= cyc_d;
            bcnt_q     <= bcnt_d;
            bit_out_q  <= bit_out_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cyc_d    = cyc_q;
        bcnt_d   = bcnt_q;
        fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            StIdle: begin
                if (!empty_o) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
                    parity_d = even_parity(fifo_rdata);
`endif
                    cyc_d    = '0;
                    bcnt_d   = '0;
                    state_d  = StStart;
                end
            end
            StStart: if (bit_tick) state_d = StData;
            StData: begin
                if (bit_tick) begin
                    shreg_d = {shreg_q[UART_DATA_W-2:0], 1'b0};
                    if (bcnt_q == 8'(UART_DATA_W - 1)) begin
                        bcnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bcnt_d = bcnt_q + 8'd1;
                    end
                end
            end
            StParity: if (bit_tick) state_d = StStop;
            StStop: begin
                if (bit_tick) begin
                    if (last_stop) begin
                        bcnt_d  = '0;
                        state_d = StIdle;
                    end else begin
                        bcnt_d = bcnt_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Cycle counter only runs inside a frame and wraps at each bit boundary.
        if (state_q != StIdle) cyc_d = bit_tick ? '0 : cyc_q + 1'b1;
    end

    // Line level is registered from the next state so it changes on the same edge as the FSM.
    always_comb begin
        bit_out_d = IDLE_LEVEL;
        case (state_d)
            StStart:  bit_out_d = START_LEVEL;
            StData:   bit_out_d = shreg_d[UART_DATA_W-1];
`ifdef UART_TX_PARITY_EN
            StParity: bit_out_d = parity_d;
`endif
            default:  bit_out_d = IDLE_LEVEL;
        endcase
        overflow_d = overflow_q | (wr_en_i & full_o);
        tx_done_o  = (state_q == StStop) && bit_tick && last_stop;
        busy_o     = (state_q != StIdle);
    end

    assign bit_out_o  = bit_out_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed self-checking bench for uart_tx_buffered; a bench-side line monitor deserializes frames.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in, data_in4;
    logic       wr_en, wr_en4;
    logic       full, empty, bit_out, busy, tx_done, overflow;
    logic       full4, empty4, bit_out4, busy4, tx_done4, overflow4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

`ifdef UART_TX_PARITY_EN
    localparam int FrameCyc = 13;
    localparam int StopSt   = 10;
`else
    localparam int FrameCyc = 12;
    localparam int StopSt   = 9;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_tx_buffered dut (
        .clk       (clk),
        .rst       (rst),
        .data_in_i (data_in),
        .wr_en_i   (wr_en),
        .full_o    (full),
        .empty_o   (empty),
        .bit_out_o (bit_out),
        .busy_o    (busy),
        .tx_done_o (tx_done),
        .overflow_o(overflow)
    );

    uart_tx_buffered #(
        .CLKS_PER_BIT(4)
    ) dut4 (
        .clk       (clk),
        .rst       (rst),
        .data_in_i (data_in4),
        .wr_en_i   (wr_en4),
        .full_o    (full4),
        .empty_o   (empty4),
        .bit_out_o (bit_out4),
        .busy_o    (busy4),
        .tx_done_o (tx_done4),
        .overflow_o(overflow4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame monitor for the 1-clk/bit instance.
    logic [7:0] rx_q[$];
    int         rx_start_q[$];
    int         rx_bad_q[$];
    logic       rx_par_q[$];
    int         mst = 0;
    int         mstart = 0;
    int         mbad = 0;
    logic [7:0] msh = '0;
    logic       mpar = 1'b0;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            mst = 0;
        end else if (mst == 0) begin
            if (bit_out === 1'b0) begin
                mst = 1;
                mstart = cyc;
                mbad = (tx_done !== 1'b0) ? 1 : 0;
                mpar = 1'b0;
            end
        end else if (mst <= 8) begin
            msh = {msh[6:0], bit_out};
            if (tx_done !== 1'b0) mbad++;
            mst++;
        end else if (mst < StopSt) begin
            mpar = bit_out;
            if (tx_done !== 1'b0) mbad++;
            mst++;
        end else if (mst == StopSt) begin
            if (bit_out !== 1'b1 || tx_done !== 1'b0) mbad++;
            mst++;
        end else begin
            if (bit_out !== 1'b1 || tx_done !== 1'b1) mbad++;
            rx_q.push_back(msh);
            rx_start_q.push_back(mstart);
            rx_bad_q.push_back(mbad);
            rx_par_q.push_back(mpar);
            mst = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        data_in = d;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_start_q.delete();
        rx_bad_q.delete();
        rx_par_q.delete();
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check_eq("rx_frames_arrived", (rx_q.size() >= n) ? 1 : 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic t2_exp[12];
    int   t2_n;
    logic t5_exp[12];
    int   t5_n;

    initial begin
`ifdef UART_TX_PARITY_EN
        t2_exp = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1, 1};
        t2_n   = 12;
        t5_exp = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1};
        t5_n   = 12;
`else
        t2_exp = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1, 1};
        t2_n   = 11;
        t5_exp = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        t5_n   = 11;
`endif
        data_in  = '0;
        wr_en    = 1'b0;
        data_in4 = '0;
        wr_en4   = 1'b0;
        rst      = 1'b1;
        repeat (2) step();
        check_eq("rst_bit_out", bit_out, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_tx_done", tx_done, 0);
        check_eq("rst_bit_out4", bit_out4, 1);
        rst = 1'b0;
        step();

        // Reset mid-DATA with a second byte queued.
        write_byte(8'h0F);
        write_byte(8'h55);
        repeat (3) step();
        check_eq("t1_pre_bit_low", bit_out, 0);
        check_eq("t1_pre_busy", busy, 1);
        check_eq("t1_pre_queued", empty, 0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t1_bit_out", bit_out, 1);
        check_eq("t1_busy", busy, 0);
        check_eq("t1_empty", empty, 1);
        check_eq("t1_tx_done", tx_done, 0);
        step();
        rst = 1'b0;
        repeat (20) begin
            step();
            check_eq("t1_quiet_line", bit_out, 1);
        end
        check_eq("t1_no_frames", rx_q.size(), 0);
        clear_rx();

        // Single byte, bit-exact line trace.
        write_byte(8'hA5);
        check_eq("t2_latency_idle", bit_out, 1);
        for (int i = 0; i < t2_n; i++) begin
            step();
            check_eq($sformatf("t2_bit%0d", i), bit_out, t2_exp[i]);
            check_eq($sformatf("t2_done%0d", i), tx_done, (i == t2_n - 1) ? 1 : 0);
        end
        step();
        check_eq("t2_idle_busy", busy, 0);
        check_eq("t2_idle_bit", bit_out, 1);
        check_eq("t2_rx_count", rx_q.size(), 1);
        if (rx_q.size() == 1) begin
            check_eq("t2_rx_byte", rx_q[0], 8'hA5);
            check_eq("t2_rx_frame_ok", rx_bad_q[0], 0);
        end
        clear_rx();

        // Back-to-back writes.
        data_in = 8'h00;
        wr_en = 1'b1;
        step();
        data_in = 8'hFF;
        step();
        data_in = 8'h3C;
        step();
        wr_en = 1'b0;
        wait_rx(3, 100);
        if (rx_q.size() >= 3) begin
            check_eq("t3_byte0", rx_q[0], 8'h00);
            check_eq("t3_byte1", rx_q[1], 8'hFF);
            check_eq("t3_byte2", rx_q[2], 8'h3C);
            check_eq("t3_gap01", rx_start_q[1] - rx_start_q[0], FrameCyc);
            check_eq("t3_gap12", rx_start_q[2] - rx_start_q[1], FrameCyc);
            check_eq("t3_frames_ok", rx_bad_q[0] + rx_bad_q[1] + rx_bad_q[2], 0);
        end
        check_eq("t3_overflow", overflow, 0);
        repeat (5) step();
        clear_rx();

        // Fill FIFO while busy, then one write too many.
        write_byte(8'h11);
        data_in = 8'h22;
        wr_en = 1'b1;
        step();
        data_in = 8'h33;
        step();
        data_in = 8'h44;
        step();
        data_in = 8'h55;
        step();
        check_eq("t4_full", full, 1);
        check_eq("t4_no_overflow_yet", overflow, 0);
        data_in = 8'h66;
        step();
        wr_en = 1'b0;
        check_eq("t4_overflow", overflow, 1);
        check_eq("t4_still_full", full, 1);
        wait_rx(5, 200);
        repeat (30) step();
        check_eq("t4_rx_count", rx_q.size(), 5);
        if (rx_q.size() == 5) begin
            check_eq("t4_byte0", rx_q[0], 8'h11);
            check_eq("t4_byte1", rx_q[1], 8'h22);
            check_eq("t4_byte2", rx_q[2], 8'h33);
            check_eq("t4_byte3", rx_q[3], 8'h44);
            check_eq("t4_byte4", rx_q[4], 8'h55);
        end
        check_eq("t4_overflow_sticky", overflow, 1);
        check_eq("t4_empty", empty, 1);
        check_eq("t4_idle", busy, 0);
        clear_rx();

        // Four clocks per bit on the second instance.
        data_in4 = 8'h81;
        wr_en4 = 1'b1;
        step();
        wr_en4 = 1'b0;
        check_eq("t5_latency_idle", bit_out4, 1);
        for (int i = 0; i < 4 * t5_n; i++) begin
            step();
            check_eq($sformatf("t5_bit_c%0d", i), bit_out4, t5_exp[i / 4]);
            check_eq($sformatf("t5_done_c%0d", i), tx_done4, (i == 4 * t5_n - 1) ? 1 : 0);
        end
        step();
        check_eq("t5_idle_busy", busy4, 0);
        check_eq("t5_idle_bit", bit_out4, 1);
        check_eq("t5_overflow", overflow4, 0);

`ifdef UART_TX_PARITY_EN
        data_in = 8'h07;
        wr_en = 1'b1;
        step();
        data_in = 8'h03;
        step();
        wr_en = 1'b0;
        wait_rx(2, 100);
        if (rx_q.size() >= 2) begin
            check_eq("t6_byte0", rx_q[0], 8'h07);
            check_eq("t6_parity0", rx_par_q[0], 1);
            check_eq("t6_byte1", rx_q[1], 8'h03);
            check_eq("t6_parity1", rx_par_q[1], 0);
            check_eq("t6_frames_ok", rx_bad_q[0] + rx_bad_q[1], 0);
        end
        clear_rx();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
